axi4_stream_pkt_fifo: RTL and testbench

AXI4_STREAM_PKT_FIFO -- requirements
Module: axi4_stream_pkt_fifo

---
 rtl/axi4_stream_fifo_pkg.sv | 26 ++
 rtl/axi4_stream_if.sv | 20 ++
 rtl/dual_port_ram.sv | 20 ++
 rtl/axi4_stream_pkt_fifo.sv | 120 ++++++++++++
 tb/tb_axi4_stream_pkt_fifo.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_fifo_pkg.sv
// rtl/axi4_stream_fifo_pkg.sv - shared word layout, width helper and write-side FSM states
package axi4_stream_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Stored word at default widths; the FIFO packs the fields in this same order at any width.
  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [0:0]  tuser;
    logic [0:0]  tdest;
    logic [0:0]  tid;
  } axis_word_t;

  function automatic int word_width(input int data_w, input int user_w,
                                    input int dest_w, input int id_w);
    return data_w + 2 * (data_w / 8) + 1 + user_w + dest_w + id_w;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid, input tready);
  modport slave  (input tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid, output tready);
endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM, one write port and one registered read port
module dual_port_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi4_stream_pkt_fifo.sv
// rtl/axi4_stream_pkt_fifo.sv - AXI4-Stream FIFO, store-and-forward with drop or plain word mode
module axi4_stream_pkt_fifo
  import axi4_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int DEST_WIDTH      = 1,
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 8,
  parameter int PKT_MODE        = 1,
  parameter int ALMOST_FULL_LVL = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi4_stream_if.slave          pkt_i,
  axi4_stream_if.master         pkt_o,
  output logic [ADDR_WIDTH:0]   used_words_o,
  output logic [ADDR_WIDTH:0]   pkts_o,
  output logic                  almost_full_o,
  output logic [31:0]           drop_cnt_o
);
  localparam int WORD_WIDTH = word_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH, ID_WIDTH);
  localparam int LAST_BIT   = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);

  logic [ADDR_WIDTH-1:0] wr_addr, cm_addr, rd_addr;
  logic [ADDR_WIDTH:0]   used_words, unc_words, pkts, in_flight, avail;
  logic [31:0]           drop_cnt;
  wr_state_e             state;
  logic                  s1_v, out_v;
  logic [WORD_WIDTH-1:0] wr_word, ram_q, out_word;
  logic full, wr_hs, in_drop, store, drop_hit, rewind, commit, pkt_commit;
  logic pop, pop_last, out_load, issue;

  assign full         = (used_words == FULL_CNT);
  assign pkt_i.tready = (PKT_MODE != 0) ? 1'b1 : ~full;
  assign wr_hs        = pkt_i.tvalid && pkt_i.tready;
  assign in_drop      = (state == ST_DROP);

  assign store      = wr_hs && ((PKT_MODE == 0) || (!in_drop && !full));
  assign drop_hit   = (PKT_MODE != 0) && wr_hs && !in_drop && full;
  assign rewind     = (PKT_MODE != 0) && wr_hs && pkt_i.tlast && (in_drop || drop_hit);
  assign commit     = store && (pkt_i.tlast || (PKT_MODE == 0));
  assign pkt_commit = store && pkt_i.tlast;

  // Committed-but-not-issued words: everything stored, minus the open packet, minus what sits in the read pipe.
  assign in_flight = (ADDR_WIDTH+1)'(s1_v) + (ADDR_WIDTH+1)'(out_v);
  assign avail     = used_words - unc_words - in_flight;
  assign pop       = out_v && pkt_o.tready;
  assign pop_last  = pop && out_word[LAST_BIT];
  assign out_load  = s1_v && (!out_v || pkt_o.tready);
  assign issue     = (avail != '0) && (!s1_v || out_load);

  assign wr_word = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                    pkt_i.tuser, pkt_i.tdest, pkt_i.tid};
  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast,
          pkt_o.tuser, pkt_o.tdest, pkt_o.tid} = out_word;
  assign pkt_o.tvalid  = out_v;
  assign used_words_o  = used_words;
  assign pkts_o        = pkts;
  assign drop_cnt_o    = drop_cnt;
  assign almost_full_o = (used_words >= AF_LVL);

  dual_port_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(WORD_WIDTH)) u_ram (
    .clk_i (clk_i),
    .we    (store),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_addr    <= '0;
      cm_addr    <= '0;
      rd_addr    <= '0;
      used_words <= '0;
      unc_words  <= '0;
      pkts       <= '0;
      drop_cnt   <= '0;
      state      <= ST_IDLE;
      s1_v       <= 1'b0;
      out_v      <= 1'b0;
      out_word   <= '0;
    end else begin
      if (store)       wr_addr <= wr_addr + 1'b1;
      else if (rewind) wr_addr <= cm_addr;
      if (commit) cm_addr <= wr_addr + 1'b1;
      if (issue)  rd_addr <= rd_addr + 1'b1;

      used_words <= used_words + (ADDR_WIDTH+1)'(store) - (ADDR_WIDTH+1)'(pop)
                    - (rewind ? unc_words : '0);
      pkts       <= pkts + (ADDR_WIDTH+1)'(pkt_commit) - (ADDR_WIDTH+1)'(pop_last);

      if (commit || rewind) unc_words <= '0;
      else if (store)       unc_words <= unc_words + 1'b1;

      if (rewind && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;

      if (wr_hs) begin
        if (rewind)        state <= ST_IDLE;
        else if (drop_hit) state <= ST_DROP;
        else if (store)    state <= pkt_i.tlast ? ST_IDLE : ST_RUN;
      end

      if (issue)         s1_v <= 1'b1;
      else if (out_load) s1_v <= 1'b0;

      if (out_load) begin
        out_v    <= 1'b1;
        out_word <= ram_q;
      end else if (pop) begin
        out_v    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi4_stream_pkt_fifo.sv
// tb/tb_axi4_stream_pkt_fifo.sv - directed bench for packet-mode and word-mode FIFO instances
module tb_axi4_stream_pkt_fifo;
  import axi4_stream_fifo_pkg::*;

  localparam int AW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [AW:0] p_used, p_pkts, w_used, w_pkts;
  logic        p_af, w_af;
  logic [31:0] p_drop, w_drop;

  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) p_in ();
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) p_out ();
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) w_in ();
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) w_out ();

  axi4_stream_pkt_fifo #(.ADDR_WIDTH(AW), .PKT_MODE(1)) u_pkt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pkt_i         (p_in),
    .pkt_o         (p_out),
    .used_words_o  (p_used),
    .pkts_o        (p_pkts),
    .almost_full_o (p_af),
    .drop_cnt_o    (p_drop)
  );

  axi4_stream_pkt_fifo #(.ADDR_WIDTH(AW), .PKT_MODE(0)) u_word (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pkt_i         (w_in),
    .pkt_o         (w_out),
    .used_words_o  (w_used),
    .pkts_o        (w_pkts),
    .almost_full_o (w_af),
    .drop_cnt_o    (w_drop)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic axis_word_t mk_word(input int n, input logic last);
    axis_word_t w;
    w.tdata = 32'hA500_0000 ^ (32'(n) * 32'h0001_0101);
    w.tstrb = 4'(n);
    w.tkeep = ~4'(n);
    w.tlast = last;
    w.tuser = n[0];
    w.tdest = n[1];
    w.tid   = n[2];
    return w;
  endfunction

  function automatic axis_word_t got_word(input bit sel_w);
    if (sel_w)
      return {w_out.tdata, w_out.tstrb, w_out.tkeep, w_out.tlast, w_out.tuser, w_out.tdest, w_out.tid};
    return {p_out.tdata, p_out.tstrb, p_out.tkeep, p_out.tlast, p_out.tuser, p_out.tdest, p_out.tid};
  endfunction

  task automatic p_put(input axis_word_t w);
    p_in.tvalid = 1'b1;
    p_in.tdata = w.tdata; p_in.tstrb = w.tstrb; p_in.tkeep = w.tkeep; p_in.tlast = w.tlast;
    p_in.tuser = w.tuser; p_in.tdest = w.tdest; p_in.tid = w.tid;
  endtask

  task automatic w_put(input axis_word_t w);
    w_in.tvalid = 1'b1;
    w_in.tdata = w.tdata; w_in.tstrb = w.tstrb; w_in.tkeep = w.tkeep; w_in.tlast = w.tlast;
    w_in.tuser = w.tuser; w_in.tdest = w.tdest; w_in.tid = w.tid;
  endtask

  task automatic idle_inputs();
    p_put('0);
    w_put('0);
    p_in.tvalid  = 1'b0;
    w_in.tvalid  = 1'b0;
    p_out.tready = 1'b0;
    w_out.tready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic p_send_pkt(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      p_put(mk_word(base + i, i == len - 1));
      tick();
    end
    p_in.tvalid = 1'b0;
  endtask

  // Caller holds the relevant tready high; the word is consumed on the tick at the end.
  task automatic expect_word(input string tag, input bit sel_w, input axis_word_t exp);
    int waited = 0;
    while (!(sel_w ? w_out.tvalid : p_out.tvalid) && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_vld"}, 64'(sel_w ? w_out.tvalid : p_out.tvalid), 64'(1));
    check(tag, 64'(got_word(sel_w)), 64'(exp));
    tick();
  endtask

  initial begin
    int accepted;
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) tick();
    check("rst_used",  64'(p_used), 64'(0));
    check("rst_pkts",  64'(p_pkts), 64'(0));
    check("rst_drop",  64'(p_drop), 64'(0));
    check("rst_af",    64'(p_af), 64'(0));
    check("rst_tvalid", 64'(p_out.tvalid), 64'(0));
    check("rst_w_tvalid", 64'(w_out.tvalid), 64'(0));
    rst_i = 1'b0;
    tick();
    check("rel_w_tready", 64'(w_in.tready), 64'(1));
    check("rel_p_tready", 64'(p_in.tready), 64'(1));

    // Three-word packet: visible two cycles after its tlast, drained in order.
    do_reset();
    p_send_pkt(1, 3);
    check("a_pkts", 64'(p_pkts), 64'(1));
    check("a_used", 64'(p_used), 64'(3));
    check("a_vld0", 64'(p_out.tvalid), 64'(0));
    tick();
    check("a_vld1", 64'(p_out.tvalid), 64'(0));
    tick();
    check("a_vld2", 64'(p_out.tvalid), 64'(1));
    check("a_first", 64'(got_word(0)), 64'(mk_word(1, 0)));
    p_out.tready = 1'b1;
    expect_word("a1", 0, mk_word(1, 0));
    expect_word("a2", 0, mk_word(2, 0));
    check("a_pkts_mid", 64'(p_pkts), 64'(1));
    expect_word("a3", 0, mk_word(3, 1));
    check("a_pkts_end", 64'(p_pkts), 64'(0));
    check("a_vld_end", 64'(p_out.tvalid), 64'(0));
    check("a_used_end", 64'(p_used), 64'(0));

    // 12 committed words, then a 6-word packet overflows and is dropped.
    do_reset();
    for (int k = 0; k < 3; k++) p_send_pkt(16 + 4 * k, 4);
    check("b_used12", 64'(p_used), 64'(12));
    check("b_pkts3", 64'(p_pkts), 64'(3));
    check("b_af", 64'(p_af), 64'(1));
    for (int i = 0; i < 6; i++) begin
      p_put(mk_word(40 + i, i == 5));
      tick();
      if (i == 3) begin
        check("b_used16", 64'(p_used), 64'(16));
        check("b_tready_full", 64'(p_in.tready), 64'(1));
      end
    end
    p_in.tvalid = 1'b0;
    check("b_drop", 64'(p_drop), 64'(1));
    check("b_used_rew", 64'(p_used), 64'(12));
    check("b_pkts_rew", 64'(p_pkts), 64'(3));
    p_out.tready = 1'b1;
    for (int i = 0; i < 12; i++)
      expect_word($sformatf("b_w%0d", i), 0, mk_word(16 + i, (i % 4) == 3));
    repeat (4) tick();
    check("b_vld_end", 64'(p_out.tvalid), 64'(0));
    check("b_used_end", 64'(p_used), 64'(0));

    // Oversized packet is dropped; the following packet passes intact.
    do_reset();
    p_out.tready = 1'b1;
    p_send_pkt(60, 20);
    check("c_drop", 64'(p_drop), 64'(1));
    check("c_used", 64'(p_used), 64'(0));
    check("c_pkts", 64'(p_pkts), 64'(0));
    check("c_vld", 64'(p_out.tvalid), 64'(0));
    p_send_pkt(90, 2);
    expect_word("c1", 0, mk_word(90, 0));
    expect_word("c2", 0, mk_word(91, 1));
    repeat (3) tick();
    check("c_vld_end", 64'(p_out.tvalid), 64'(0));

    // Reset mid-packet: one committed packet plus two open words, drop counter nonzero.
    p_out.tready = 1'b0;
    p_send_pkt(300, 3);
    for (int i = 0; i < 2; i++) begin
      p_put(mk_word(310 + i, 1'b0));
      tick();
    end
    p_in.tvalid = 1'b0;
    check("d_used5", 64'(p_used), 64'(5));
    check("d_vld_pre", 64'(p_out.tvalid), 64'(1));
    check("d_drop_pre", 64'(p_drop), 64'(1));
    rst_i = 1'b1;
    #2;
    check("d_used", 64'(p_used), 64'(0));
    check("d_pkts", 64'(p_pkts), 64'(0));
    check("d_drop", 64'(p_drop), 64'(0));
    check("d_af", 64'(p_af), 64'(0));
    check("d_vld", 64'(p_out.tvalid), 64'(0));
    check("d_word", 64'(got_word(0)), 64'(0));
    tick();
    rst_i = 1'b0;
    tick();
    p_out.tready = 1'b1;
    p_send_pkt(400, 2);
    expect_word("d_b1", 0, mk_word(400, 0));
    expect_word("d_b2", 0, mk_word(401, 1));
    repeat (3) tick();
    check("d_vld_end", 64'(p_out.tvalid), 64'(0));
    check("d_used_end", 64'(p_used), 64'(0));

    // Word mode: backpressure at 16 words, one read frees a slot.
    do_reset();
    accepted = 0;
    for (int i = 0; i < 17; i++) begin
      w_put(mk_word(100 + i, (i % 4) == 3));
      if (w_in.tready) accepted++;
      tick();
    end
    w_in.tvalid = 1'b0;
    check("e_accepted", 64'(accepted), 64'(16));
    check("e_used16", 64'(w_used), 64'(16));
    check("e_tready_full", 64'(w_in.tready), 64'(0));
    check("e_pkts", 64'(w_pkts), 64'(4));
    w_out.tready = 1'b1;
    expect_word("e_w0", 1, mk_word(100, 0));
    w_out.tready = 1'b0;
    check("e_tready_back", 64'(w_in.tready), 64'(1));
    check("e_used15", 64'(w_used), 64'(15));
    w_out.tready = 1'b1;
    for (int i = 1; i < 16; i++)
      expect_word($sformatf("e_w%0d", i), 1, mk_word(100 + i, (i % 4) == 3));
    repeat (3) tick();
    check("e_vld_end", 64'(w_out.tvalid), 64'(0));
    check("e_used_end", 64'(w_used), 64'(0));

    // Back-to-back single-word packets at full rate.
    do_reset();
    p_out.tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      p_put(mk_word(200 + k, 1'b1));
      tick();
      if (k >= 2) begin
        check($sformatf("f_vld%0d", k), 64'(p_out.tvalid), 64'(1));
        check($sformatf("f_word%0d", k), 64'(got_word(0)), 64'(mk_word(198 + k, 1'b1)));
        check($sformatf("f_used%0d", k), 64'(p_used), 64'(3));
      end
    end
    p_in.tvalid = 1'b0;
    expect_word("f_t17", 0, mk_word(217, 1'b1));
    expect_word("f_t18", 0, mk_word(218, 1'b1));
    expect_word("f_t19", 0, mk_word(219, 1'b1));
    check("f_used_end", 64'(p_used), 64'(0));
    check("f_pkts_end", 64'(p_pkts), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
